// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller: result kinds, producer records,
// tnew-on-entry values and every forwarding select code the mux consumes.
package hazard_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'b00,
    KIND_PC8  = 2'b01,
    KIND_ALU  = 2'b10,
    KIND_DM   = 2'b11
  } kind_e;

  // Which consumer stage a selector instance serves; decides the code table.
  typedef enum logic [1:0] {
    TBL_D = 2'd0,
    TBL_E = 2'd1,
    TBL_M = 2'd2
  } sel_table_e;

  typedef struct packed {
    logic [4:0] dst;
    kind_e      kind;
    logic [1:0] tnew;
  } prod_rec_t;

  localparam prod_rec_t REC_EMPTY = '{dst: 5'd0, kind: KIND_NONE, tnew: 2'd0};

  localparam logic [1:0] TNEW_PC8  = 2'd0;
  localparam logic [1:0] TNEW_ALU  = 2'd1;
  localparam logic [1:0] TNEW_DM   = 2'd2;
  localparam logic [1:0] TNEW_NONE = 2'd0;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [2:0] FD_RD    = 3'b000;
  localparam logic [2:0] FD_PC8_E = 3'b001;
  localparam logic [2:0] FD_PC8_M = 3'b010;
  localparam logic [2:0] FD_AO_M  = 3'b011;
  localparam logic [2:0] FD_PC8_R = 3'b100;
  localparam logic [2:0] FD_AO_R  = 3'b101;

  localparam logic [2:0] FE_REG   = 3'b000;
  localparam logic [2:0] FE_PC8_M = 3'b001;
  localparam logic [2:0] FE_AO_M  = 3'b010;
  localparam logic [2:0] FE_PC8_R = 3'b011;
  localparam logic [2:0] FE_AO_R  = 3'b100;
  localparam logic [2:0] FE_WD3   = 3'b101;

  localparam logic [2:0] FM_RT_M  = 3'b000;
  localparam logic [2:0] FM_PC8_R = 3'b001;
  localparam logic [2:0] FM_AO_R  = 3'b010;
  localparam logic [2:0] FM_WD3   = 3'b011;

  function automatic logic [1:0] tnew_entry(kind_e k);
    logic [1:0] t;
    case (k)
      KIND_PC8: t = TNEW_PC8;
      KIND_ALU: t = TNEW_ALU;
      KIND_DM:  t = TNEW_DM;
      default:  t = TNEW_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [1:0] tnew_step(logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic rec_match(prod_rec_t r, logic [4:0] src);
    return (src != 5'd0) && (r.kind != KIND_NONE) && (r.dst == src);
  endfunction

  // slot 0 is the nearest producer for the given table; unused slots map to 000.
  function automatic logic [2:0] fwd_code(sel_table_e tbl, logic [1:0] slot, kind_e k);
    logic [2:0] c;
    c = 3'b000;
    case (tbl)
      TBL_D: begin
        case (slot)
          2'd0: if (k == KIND_PC8) c = FD_PC8_E;
          2'd1: begin
            if (k == KIND_PC8) c = FD_PC8_M;
            else if (k == KIND_ALU) c = FD_AO_M;
          end
          2'd2: begin
            if (k == KIND_PC8) c = FD_PC8_R;
            else if (k == KIND_ALU) c = FD_AO_R;
          end
          default: c = FD_RD;
        endcase
      end
      TBL_E: begin
        case (slot)
          2'd0: begin
            if (k == KIND_PC8) c = FE_PC8_M;
            else if (k == KIND_ALU) c = FE_AO_M;
          end
          2'd1: begin
            if (k == KIND_PC8) c = FE_PC8_R;
            else if (k == KIND_ALU) c = FE_AO_R;
            else if (k == KIND_DM) c = FE_WD3;
          end
          default: c = FE_REG;
        endcase
      end
      TBL_M: begin
        if (slot == 2'd0) begin
          if (k == KIND_PC8) c = FM_PC8_R;
          else if (k == KIND_ALU) c = FM_AO_R;
          else if (k == KIND_DM) c = FM_WD3;
        end
      end
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// D-stage operand/result descriptors into the hazard controller and the
// stall plus forwarding selects back out. No handshake: all signals are level.
interface hazard_if;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tuse_rs_d;
  logic [1:0] tuse_rt_d;
  logic [4:0] dst_d;
  logic [1:0] kind_d;
  logic       md_d;
  logic       md_busy;
  logic       stall;
  logic [2:0] f_rs_d;
  logic [2:0] f_rt_d;
  logic [2:0] f_rs_e;
  logic [2:0] f_rt_e;
  logic [2:0] f_rt_m;

  modport master (
    output rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, kind_d, md_d, md_busy,
    input  stall, f_rs_d, f_rt_d, f_rs_e, f_rt_e, f_rt_m
  );

  modport slave (
    input  rs_d, rt_d, tuse_rs_d, tuse_rt_d, dst_d, kind_d, md_d, md_busy,
    output stall, f_rs_d, f_rt_d, f_rs_e, f_rt_e, f_rt_m
  );
endinterface

// File: rtl/hz_fwd_sel.sv
// One forwarding selector: picks the nearest matching producer among three
// records (nearest first) and yields its select code and a data-stall request.
module hz_fwd_sel
  import hazard_pkg::*;
#(
  parameter sel_table_e TABLE = TBL_D
) (
  input  logic [4:0] src,
  input  logic [1:0] tuse,
  input  prod_rec_t  p0,
  input  prod_rec_t  p1,
  input  prod_rec_t  p2,
  output logic [2:0] sel,
  output logic       stall_req
);

  logic       hit;
  logic [1:0] slot;
  prod_rec_t  rec;

  always_comb begin
    hit  = 1'b0;
    slot = 2'd0;
    rec  = REC_EMPTY;
    if (rec_match(p0, src)) begin
      hit = 1'b1; slot = 2'd0; rec = p0;
    end else if (rec_match(p1, src)) begin
      hit = 1'b1; slot = 2'd1; rec = p1;
    end else if (rec_match(p2, src)) begin
      hit = 1'b1; slot = 2'd2; rec = p2;
    end
  end

  // The nearest match decides alone; an unready nearest match blocks older ones.
  always_comb begin
    sel       = 3'b000;
    stall_req = 1'b0;
    if (hit) begin
      if (rec.tnew == 2'd0) sel = fwd_code(TABLE, slot, rec.kind);
      if ((tuse != TUSE_NONE) && (slot != 2'd2) && (rec.tnew > tuse)) stall_req = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller top: E/M/W producer records, pipelined consumer registers,
// five forwarding selectors and the D-stage stall.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  hazard_if.slave  hz
);

  prod_rec_t  e_q, e_d, m_q, m_d, w_q, w_d;
  logic [4:0] rs_e_q, rs_e_d, rt_e_q, rt_e_d, rt_m_q, rt_m_d;

  logic [2:0] sel_rs_d, sel_rt_d, sel_rs_e, sel_rt_e, sel_rt_m;
  logic       req_rs_d, req_rt_d, req_rs_e, req_rt_e, req_rt_m;
  logic       stall;

  hz_fwd_sel #(.TABLE(TBL_D)) u_d_rs (
    .src(hz.rs_d), .tuse(hz.tuse_rs_d), .p0(e_q), .p1(m_q), .p2(w_q),
    .sel(sel_rs_d), .stall_req(req_rs_d)
  );

  hz_fwd_sel #(.TABLE(TBL_D)) u_d_rt (
    .src(hz.rt_d), .tuse(hz.tuse_rt_d), .p0(e_q), .p1(m_q), .p2(w_q),
    .sel(sel_rt_d), .stall_req(req_rt_d)
  );

  hz_fwd_sel #(.TABLE(TBL_E)) u_e_rs (
    .src(rs_e_q), .tuse(TUSE_NONE), .p0(m_q), .p1(w_q), .p2(REC_EMPTY),
    .sel(sel_rs_e), .stall_req(req_rs_e)
  );

  hz_fwd_sel #(.TABLE(TBL_E)) u_e_rt (
    .src(rt_e_q), .tuse(TUSE_NONE), .p0(m_q), .p1(w_q), .p2(REC_EMPTY),
    .sel(sel_rt_e), .stall_req(req_rt_e)
  );

  hz_fwd_sel #(.TABLE(TBL_M)) u_m_rt (
    .src(rt_m_q), .tuse(TUSE_NONE), .p0(w_q), .p1(REC_EMPTY), .p2(REC_EMPTY),
    .sel(sel_rt_m), .stall_req(req_rt_m)
  );

  // Outputs are forced idle while reset is held, independent of the D inputs.
  assign stall = rst_n & (req_rs_d | req_rt_d | req_rs_e | req_rt_e | req_rt_m |
                          (hz.md_d & hz.md_busy));

  assign hz.stall  = stall;
  assign hz.f_rs_d = !rst_n ? FD_RD : ((stall && sel_rs_d == FD_PC8_E) ? FD_RD : sel_rs_d);
  assign hz.f_rt_d = !rst_n ? FD_RD : ((stall && sel_rt_d == FD_PC8_E) ? FD_RD : sel_rt_d);
  assign hz.f_rs_e = rst_n ? sel_rs_e : FE_REG;
  assign hz.f_rt_e = rst_n ? sel_rt_e : FE_REG;
  assign hz.f_rt_m = rst_n ? sel_rt_m : FM_RT_M;

  always_comb begin
    if (stall) begin
      e_d    = REC_EMPTY;
      rs_e_d = 5'd0;
      rt_e_d = 5'd0;
    end else begin
      e_d.dst  = hz.dst_d;
      e_d.kind = kind_e'(hz.kind_d);
      e_d.tnew = tnew_entry(kind_e'(hz.kind_d));
      rs_e_d   = hz.rs_d;
      rt_e_d   = hz.rt_d;
    end
    m_d      = e_q;
    m_d.tnew = tnew_step(e_q.tnew);
    w_d      = m_q;
    w_d.tnew = tnew_step(m_q.tnew);
    rt_m_d   = rt_e_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= REC_EMPTY;
      m_q    <= REC_EMPTY;
      w_q    <= REC_EMPTY;
      rs_e_q <= 5'd0;
      rt_e_q <= 5'd0;
      rt_m_q <= 5'd0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      rs_e_q <= rs_e_d;
      rt_e_q <= rt_e_d;
      rt_m_q <= rt_m_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios then randomized traffic,
// checked against an instruction-level model of the E/M/W stages.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_if hz ();

  hazard_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: in-flight instructions by stage index 0=E, 1=M, 2=W.
  int mdst[3];
  int mkind[3];
  int mrs_e, mrt_e, mrt_m;

  logic       exp_stall;
  logic [2:0] e_rs_d, e_rt_d, e_rs_e, e_rt_e, e_rt_m;

  // Cycles from entering E until the result exists.
  function automatic int lat(int k);
    if (k == 1) return 0;
    if (k == 2) return 1;
    if (k == 3) return 2;
    return 0;
  endfunction

  function automatic int tnew_of(int s);
    int t;
    t = lat(mkind[s]) - s;
    return (t < 0) ? 0 : t;
  endfunction

  function automatic int nearest(int src, int from);
    if (src == 0) return -1;
    for (int s = from; s < 3; s++)
      if (mdst[s] == src && mkind[s] != 0) return s;
    return -1;
  endfunction

  task automatic d_sel(input int src, input int tuse, output logic [2:0] code, output logic st);
    int s;
    int k;
    code = 3'd0;
    st   = 1'b0;
    s = nearest(src, 0);
    if (s >= 0) begin
      k = mkind[s];
      if (tnew_of(s) == 0) begin
        if (s == 0 && k == 1) code = 3'd1;
        if (s == 1 && k == 1) code = 3'd2;
        if (s == 1 && k == 2) code = 3'd3;
        if (s == 2 && k == 1) code = 3'd4;
        if (s == 2 && k == 2) code = 3'd5;
      end
      if (tuse != 3 && s < 2 && tnew_of(s) > tuse) st = 1'b1;
    end
  endtask

  function automatic logic [2:0] e_sel(int src);
    int s;
    int k;
    s = nearest(src, 1);
    if (s < 0 || tnew_of(s) != 0) return 3'd0;
    k = mkind[s];
    if (s == 1 && k == 1) return 3'd1;
    if (s == 1 && k == 2) return 3'd2;
    if (s == 2 && k == 1) return 3'd3;
    if (s == 2 && k == 2) return 3'd4;
    if (s == 2 && k == 3) return 3'd5;
    return 3'd0;
  endfunction

  function automatic logic [2:0] m_sel(int src);
    int s;
    s = nearest(src, 2);
    if (s < 0) return 3'd0;
    if (mkind[s] == 1) return 3'd1;
    if (mkind[s] == 2) return 3'd2;
    if (mkind[s] == 3) return 3'd3;
    return 3'd0;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 3; s++) begin
      mdst[s]  = 0;
      mkind[s] = 0;
    end
    mrs_e = 0;
    mrt_e = 0;
    mrt_m = 0;
  endtask

  task automatic compute_expected();
    logic st_rs, st_rt;
    exp_stall = 1'b0;
    e_rs_d = 3'd0; e_rt_d = 3'd0; e_rs_e = 3'd0; e_rt_e = 3'd0; e_rt_m = 3'd0;
    if (!rst_n) return;
    d_sel(int'(hz.rs_d), int'(hz.tuse_rs_d), e_rs_d, st_rs);
    d_sel(int'(hz.rt_d), int'(hz.tuse_rt_d), e_rt_d, st_rt);
    exp_stall = st_rs | st_rt | (hz.md_d & hz.md_busy);
    if (exp_stall && e_rs_d == 3'd1) e_rs_d = 3'd0;
    if (exp_stall && e_rt_d == 3'd1) e_rt_d = 3'd0;
    e_rs_e = e_sel(mrs_e);
    e_rt_e = e_sel(mrt_e);
    e_rt_m = m_sel(mrt_m);
  endtask

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_now();
    compute_expected();
    check("stall",  {2'b00, hz.stall}, {2'b00, exp_stall});
    check("f_rs_d", hz.f_rs_d, e_rs_d);
    check("f_rt_d", hz.f_rt_d, e_rt_d);
    check("f_rs_e", hz.f_rs_e, e_rs_e);
    check("f_rt_e", hz.f_rt_e, e_rt_e);
    check("f_rt_m", hz.f_rt_m, e_rt_m);
  endtask

  task automatic drive(input int rs, input int trs, input int rt, input int trt,
                       input int dst, input int kind, input int md, input int busy);
    hz.rs_d      = 5'(rs);
    hz.tuse_rs_d = 2'(trs);
    hz.rt_d      = 5'(rt);
    hz.tuse_rt_d = 2'(trt);
    hz.dst_d     = 5'(dst);
    hz.kind_d    = 2'(kind);
    hz.md_d      = 1'(md);
    hz.md_busy   = 1'(busy);
    #2;
    check_now();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      mdst[2] = mdst[1]; mkind[2] = mkind[1];
      mdst[1] = mdst[0]; mkind[1] = mkind[0];
      mrt_m   = mrt_e;
      if (exp_stall) begin
        mdst[0] = 0; mkind[0] = 0; mrs_e = 0; mrt_e = 0;
      end else begin
        mdst[0] = int'(hz.dst_d);
        mkind[0] = (hz.dst_d == 5'd0) ? 0 : int'(hz.kind_d);
        mrs_e = int'(hz.rs_d);
        mrt_e = int'(hz.rt_d);
      end
    end
    #1;
  endtask

  task automatic nop();
    drive(0, 3, 0, 3, 0, 0, 0, 0);
    tick();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_now();
    check("rst_stall", {2'b00, hz.stall}, 3'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int r_rs, r_trs, r_rt, r_trt, r_dst, r_kind, r_md, r_busy;

  initial begin
    rst_n = 1'b0;
    model_reset();
    exp_stall = 1'b0;
    // Reset holds every output idle even with a mult/div request pending.
    drive(1, 0, 1, 0, 1, 2, 1, 1);
    check("reset_stall", {2'b00, hz.stall}, 3'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // lw $1 ; addu $2,$1,$3
    drive(0, 3, 0, 3, 1, 3, 0, 0); tick();
    drive(1, 1, 3, 1, 2, 2, 0, 0);
    check("lw_use_stall", {2'b00, hz.stall}, 3'd1); tick();
    drive(1, 1, 3, 1, 2, 2, 0, 0);
    check("lw_use_release", {2'b00, hz.stall}, 3'd0); tick();
    drive(0, 3, 0, 3, 0, 0, 0, 0);
    check("lw_use_wd3", hz.f_rs_e, 3'd5); tick();
    nop(); nop(); nop();

    // addu $1 ; beq $1
    drive(0, 3, 0, 3, 1, 2, 0, 0); tick();
    drive(1, 0, 0, 3, 0, 0, 0, 0);
    check("beq_stall", {2'b00, hz.stall}, 3'd1); tick();
    drive(1, 0, 0, 3, 0, 0, 0, 0);
    check("beq_ao_m", hz.f_rs_d, 3'd3); tick();
    nop(); nop(); nop();

    // jal ; jr $31
    drive(0, 3, 0, 3, 31, 1, 0, 0); tick();
    drive(31, 0, 0, 3, 0, 0, 0, 0);
    check("jr_pc8_e", hz.f_rs_d, 3'd1);
    check("jr_nostall", {2'b00, hz.stall}, 3'd0); tick();
    nop(); nop(); nop();

    // addu $5 ; addu $5 ; sw $5
    drive(0, 3, 0, 3, 5, 2, 0, 0); tick();
    drive(0, 3, 0, 3, 5, 2, 0, 0); tick();
    drive(0, 1, 5, 2, 0, 0, 0, 0);
    check("sw_nostall", {2'b00, hz.stall}, 3'd0); tick();
    drive(0, 3, 0, 3, 0, 0, 0, 0);
    check("sw_rt_e", hz.f_rt_e, 3'd2); tick();
    drive(0, 3, 0, 3, 0, 0, 0, 0);
    check("sw_rt_m", hz.f_rt_m, 3'd2); tick();
    nop(); nop();

    // Writes to $0 never forward or stall.
    drive(0, 3, 0, 3, 0, 3, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 2, 0, 0);
    check("zero_stall", {2'b00, hz.stall}, 3'd0); tick();
    nop(); nop();

    // Mult/div busy for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(0, 3, 0, 3, 7, 2, 1, 1);
      check("md_stall", {2'b00, hz.stall}, 3'd1); tick();
    end
    drive(0, 3, 0, 3, 7, 2, 1, 0);
    check("md_release", {2'b00, hz.stall}, 3'd0); tick();
    nop(); nop(); nop();

    // rs == rt against a load: one shared stall, identical codes.
    drive(0, 3, 0, 3, 4, 3, 0, 0); tick();
    drive(4, 0, 4, 0, 0, 0, 0, 0);
    check("same_src", hz.f_rs_d, hz.f_rt_d); tick();

    // Reset while stalled.
    drive(0, 3, 0, 3, 1, 3, 0, 0); tick();
    drive(1, 1, 1, 1, 2, 2, 1, 1);
    async_reset();
    nop(); nop();

    exp_stall = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!exp_stall) begin
        r_rs   = $urandom_range(0, 4);
        r_rt   = $urandom_range(0, 4);
        r_trs  = $urandom_range(0, 3);
        r_trt  = $urandom_range(0, 3);
        r_dst  = $urandom_range(0, 4);
        r_kind = $urandom_range(0, 3);
        r_md   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      end
      r_busy = ($urandom_range(0, 2) == 0) ? 1 : 0;
      drive(r_rs, r_trs, r_rt, r_trt, r_dst, r_kind, r_md, r_busy);
      if (i == 250) begin
        async_reset();
        exp_stall = 1'b0;
      end else begin
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
